// File: rtl/cpu_memory_stage_pkg.sv
// Shared types for the memory stage.
//   execute_data_t : item handed over by execute (tag handshake + memory op)
//   memory_data_t  : item handed on to writeback
//   mem_access_t   : the parts of an accepted memory op kept for its whole bus transaction
package cpu_memory_stage_pkg;

  localparam int TAG_W = 4;
  localparam int REG_W = 5;
  localparam int XLEN  = 32;

  // Access width in bytes; the encoding is the byte count.
  typedef enum logic [2:0] {
    MEM_BYTE = 3'd1,
    MEM_HALF = 3'd2,
    MEM_WORD = 3'd4
  } mem_width_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [REG_W-1:0] inst_rd;
    logic [XLEN-1:0]  rd;
    logic             mem_read;
    logic             mem_write;
    logic             mem_flush;
    mem_width_e       mem_width;
    logic             mem_signed;
    logic [XLEN-1:0]  mem_address;
    logic [REG_W-1:0] mem_inst_rd;
  } execute_data_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [REG_W-1:0] inst_rd;
    logic [XLEN-1:0]  rd;
  } memory_data_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [REG_W-1:0] mem_inst_rd;
    mem_width_e       width;
    logic             sign_extend;
    logic [1:0]       lane;
    logic [XLEN-1:0]  store_data;
  } mem_access_t;

  // Half on an odd byte or word off a word boundary.
  function automatic logic is_misaligned(mem_width_e width, logic [1:0] lane);
    case (width)
      MEM_HALF: return lane[0];
      MEM_WORD: return lane != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

  // Rounds the byte lane down to the natural boundary of the access.
  function automatic logic [1:0] aligned_lane(mem_width_e width, logic [1:0] lane);
    case (width)
      MEM_HALF: return {lane[1], 1'b0};
      MEM_WORD: return 2'b00;
      default:  return lane;
    endcase
  endfunction

endpackage

// File: rtl/cpu_memory_stage_load_store_align.sv
// Combinational lane handling for the memory stage (cpu_load_store_align).
//   width, sign_extend, lane : access description (lane = address[1:0])
//   rdata                    : word read from the bus
//   store_data               : register value to store (low bytes significant)
//   load_value               : selected lane(s), zero- or sign-extended
//   merged_wdata             : rdata with the addressed lane(s) replaced by store_data
module cpu_memory_stage_load_store_align
  import cpu_memory_stage_pkg::*;
(
  input  mem_width_e  width,
  input  logic        sign_extend,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged_wdata
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [3:0]  byte_enable;
  logic [31:0] store_replicated;

  always_comb begin
    load_byte = rdata[{lane, 3'b000} +: 8];
    load_half = lane[1] ? rdata[31:16] : rdata[15:0];
    case (width)
      MEM_BYTE: load_value = {{24{sign_extend & load_byte[7]}}, load_byte};
      MEM_HALF: load_value = {{16{sign_extend & load_half[15]}}, load_half};
      default:  load_value = rdata;
    endcase
  end

  // Replicating the store value puts it in every lane; the byte enables pick the right one.
  always_comb begin
    case (width)
      MEM_BYTE: begin
        store_replicated = {4{store_data[7:0]}};
        byte_enable      = 4'b0001 << lane;
      end
      MEM_HALF: begin
        store_replicated = {2{store_data[15:0]}};
        byte_enable      = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_replicated = store_data;
        byte_enable      = 4'b1111;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_wdata[gi*8 +: 8] = byte_enable[gi] ? store_replicated[gi*8 +: 8]
                                                      : rdata[gi*8 +: 8];
  end

endmodule

// File: rtl/cpu_memory_stage.sv
// Memory pipeline stage: takes items from execute by tag handshake, runs loads, stores
// (sub-word stores as read-modify-write) and cache flushes on the data bus, and hands
// results to writeback. Non-memory items pass through in one cycle.
//   i_clock, i_reset        : clock, asynchronous active-high reset
//   o_fault                 : sticky misalignment flag
//   o_busy                  : stage cannot take a new item this cycle
//   i_data / o_data         : execute item in, writeback item out
//   o_bus_request/rw/flush  : bus control, held until i_bus_ready
//   o_bus_address/wdata     : word address and write data
//   i_bus_ready/i_bus_rdata : completion pulse and read data
module cpu_memory_stage
  import cpu_memory_stage_pkg::*;
#(
  parameter bit FAULT_ON_MISALIGN = 1'b1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  output logic          o_fault,
  output logic          o_busy,
  input  execute_data_t i_data,
  output memory_data_t  o_data,
  output logic          o_bus_request,
  output logic          o_bus_rw,
  output logic          o_bus_flush,
  output logic [31:0]   o_bus_address,
  output logic [31:0]   o_bus_wdata,
  input  logic          i_bus_ready,
  input  logic [31:0]   i_bus_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RMW_READ,
    ST_RMW_WRITE,
    ST_FLUSH
  } state_e;

  state_e       state_reg, state_next;
  memory_data_t data_reg, data_next;
  mem_access_t  access_reg, access_next;
  logic         fault_reg, fault_next;
  logic         request_reg, request_next;
  logic         rw_reg, rw_next;
  logic         flush_reg, flush_next;
  logic [31:0]  address_reg, address_next;
  logic [31:0]  wdata_reg, wdata_next;

  logic         new_item, mem_op, misaligned, bus_done;
  logic         accept, accept_pass, accept_flush, accept_access, accept_fault;
  logic [1:0]   lane_in;
  logic [31:0]  load_value, merged_wdata;

  assign new_item   = i_data.tag != data_reg.tag;
  assign mem_op     = i_data.mem_read | i_data.mem_write | i_data.mem_flush;
  assign misaligned = is_misaligned(i_data.mem_width, i_data.mem_address[1:0]);
  assign lane_in    = FAULT_ON_MISALIGN ? i_data.mem_address[1:0]
                                        : aligned_lane(i_data.mem_width, i_data.mem_address[1:0]);

  // Flush wins over read/write if the decoder ever sets both.
  assign accept        = (state_reg == ST_IDLE) && new_item;
  assign accept_pass   = accept && !mem_op;
  assign accept_flush  = accept && i_data.mem_flush;
  assign accept_access = accept && !i_data.mem_flush && (i_data.mem_read || i_data.mem_write);
  assign accept_fault  = accept_access && misaligned && FAULT_ON_MISALIGN;

  // Ready only counts while something is outstanding; the RMW_WRITE gap cycle has nothing.
  assign bus_done = i_bus_ready && (request_reg || flush_reg);

  assign o_busy = (state_reg != ST_IDLE) || (new_item && mem_op);

  cpu_memory_stage_load_store_align u_align (
    .width        (access_reg.width),
    .sign_extend  (access_reg.sign_extend),
    .lane         (access_reg.lane),
    .rdata        (i_bus_rdata),
    .store_data   (access_reg.store_data),
    .load_value   (load_value),
    .merged_wdata (merged_wdata)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept_flush)                      state_next = ST_FLUSH;
        else if (accept_access && !accept_fault) begin
          if (i_data.mem_read)                 state_next = ST_READ;
          else if (i_data.mem_width == MEM_WORD) state_next = ST_WRITE;
          else                                 state_next = ST_RMW_READ;
        end
      end
      ST_READ, ST_WRITE, ST_FLUSH, ST_RMW_WRITE:
        if (bus_done) state_next = ST_IDLE;
      ST_RMW_READ:
        if (bus_done) state_next = ST_RMW_WRITE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    data_next    = data_reg;
    access_next  = access_reg;
    fault_next   = fault_reg;
    request_next = request_reg;
    rw_next      = rw_reg;
    flush_next   = flush_reg;
    address_next = address_reg;
    wdata_next   = wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept_pass) begin
          data_next = '{tag: i_data.tag, inst_rd: i_data.inst_rd, rd: i_data.rd};
        end else if (accept_flush) begin
          flush_next      = 1'b1;
          access_next.tag = i_data.tag;
        end else if (accept_fault) begin
          // Retire the tag anyway so execute is not stalled forever.
          fault_next    = 1'b1;
          data_next.tag = i_data.tag;
        end else if (accept_access) begin
          access_next  = '{tag:         i_data.tag,
                           mem_inst_rd: i_data.mem_inst_rd,
                           width:       i_data.mem_width,
                           sign_extend: i_data.mem_signed,
                           lane:        lane_in,
                           store_data:  i_data.rd};
          address_next = {i_data.mem_address[31:2], 2'b00};
          wdata_next   = i_data.rd;
          rw_next      = i_data.mem_write && (i_data.mem_width == MEM_WORD);
          request_next = 1'b1;
        end
      end
      ST_READ: begin
        if (bus_done) begin
          request_next = 1'b0;
          data_next    = '{tag: access_reg.tag, inst_rd: access_reg.mem_inst_rd, rd: load_value};
        end
      end
      ST_RMW_READ: begin
        // Drop the request here; rw and wdata change only while request is low.
        if (bus_done) begin
          request_next = 1'b0;
          rw_next      = 1'b1;
          wdata_next   = merged_wdata;
        end
      end
      ST_WRITE, ST_RMW_WRITE: begin
        if (!request_reg) begin
          request_next = 1'b1;
        end else if (bus_done) begin
          request_next      = 1'b0;
          rw_next           = 1'b0;
          data_next.inst_rd = '0;
          data_next.tag     = access_reg.tag;
        end
      end
      ST_FLUSH: begin
        if (bus_done) begin
          flush_next    = 1'b0;
          data_next.tag = access_reg.tag;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      data_reg    <= '0;
      access_reg  <= '0;
      fault_reg   <= 1'b0;
      request_reg <= 1'b0;
      rw_reg      <= 1'b0;
      flush_reg   <= 1'b0;
      address_reg <= '0;
      wdata_reg   <= '0;
    end else begin
      data_reg    <= data_next;
      access_reg  <= access_next;
      fault_reg   <= fault_next;
      request_reg <= request_next;
      rw_reg      <= rw_next;
      flush_reg   <= flush_next;
      address_reg <= address_next;
      wdata_reg   <= wdata_next;
    end
  end

  assign o_data        = data_reg;
  assign o_fault       = fault_reg;
  assign o_bus_request = request_reg;
  assign o_bus_rw      = rw_reg;
  assign o_bus_flush   = flush_reg;
  assign o_bus_address = address_reg;
  assign o_bus_wdata   = wdata_reg;

endmodule

// File: tb/tb_cpu_memory_stage.sv
// Directed bench for cpu_memory_stage.
module tb_cpu_memory_stage;
  import cpu_memory_stage_pkg::*;

  logic          i_clock;
  logic          i_reset;
  logic          o_fault;
  logic          o_busy;
  execute_data_t i_data;
  memory_data_t  o_data;
  logic          o_bus_request;
  logic          o_bus_rw;
  logic          o_bus_flush;
  logic [31:0]   o_bus_address;
  logic [31:0]   o_bus_wdata;
  logic          i_bus_ready;
  logic [31:0]   i_bus_rdata;

  int checks = 0;
  int errors = 0;

  cpu_memory_stage #(.FAULT_ON_MISALIGN(1'b1)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .o_fault       (o_fault),
    .o_busy        (o_busy),
    .i_data        (i_data),
    .o_data        (o_data),
    .o_bus_request (o_bus_request),
    .o_bus_rw      (o_bus_rw),
    .o_bus_flush   (o_bus_flush),
    .o_bus_address (o_bus_address),
    .o_bus_wdata   (o_bus_wdata),
    .i_bus_ready   (i_bus_ready),
    .i_bus_rdata   (i_bus_rdata)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic set_item(input logic [3:0] t_tag, input logic [4:0] t_inst_rd,
                          input logic [31:0] t_rd, input logic t_read, input logic t_write,
                          input logic t_flush, input mem_width_e t_width, input logic t_signed,
                          input logic [31:0] t_addr, input logic [4:0] t_mem_inst_rd);
    i_data.tag         = t_tag;
    i_data.inst_rd     = t_inst_rd;
    i_data.rd          = t_rd;
    i_data.mem_read    = t_read;
    i_data.mem_write   = t_write;
    i_data.mem_flush   = t_flush;
    i_data.mem_width   = t_width;
    i_data.mem_signed  = t_signed;
    i_data.mem_address = t_addr;
    i_data.mem_inst_rd = t_mem_inst_rd;
  endtask

  memory_data_t exp_data;

  initial begin
    i_reset     = 1'b1;
    i_data      = '0;
    i_bus_ready = 1'b0;
    i_bus_rdata = '0;
    tick();
    tick();
    chk("reset_o_data", o_data, 0);
    chk("reset_fault", o_fault, 0);
    chk("reset_request", o_bus_request, 0);
    chk("reset_flush", o_bus_flush, 0);
    chk("reset_address", o_bus_address, 0);
    chk("reset_busy", o_busy, 0);
    i_reset = 1'b0;
    tick();

    // ALU pass-through
    set_item(4'd1, 5'd5, 32'h1234, 0, 0, 0, MEM_WORD, 0, 32'h0, 5'd0);
    #1;
    chk("pass_busy", o_busy, 0);
    chk("pass_tag_before", o_data.tag, 0);
    tick();
    exp_data = '{tag: 4'd1, inst_rd: 5'd5, rd: 32'h1234};
    chk("pass_data", o_data, exp_data);
    chk("pass_request", o_bus_request, 0);
    $display("pass-through tag=1 rd=%0h", o_data.rd);

    // lb signed @0x103
    set_item(4'd2, 5'd0, 32'h0, 1, 0, 0, MEM_BYTE, 1, 32'h103, 5'd7);
    #1;
    chk("lb_busy_comb", o_busy, 1);
    tick();
    chk("lb_request", o_bus_request, 1);
    chk("lb_rw", o_bus_rw, 0);
    chk("lb_address", o_bus_address, 32'h100);
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'h80FF_FFFF;
    tick();
    i_bus_ready = 1'b0;
    exp_data = '{tag: 4'd2, inst_rd: 5'd7, rd: 32'hFFFF_FF80};
    chk("lb_data", o_data, exp_data);
    chk("lb_request_drop", o_bus_request, 0);
    chk("lb_busy_after", o_busy, 0);
    $display("lb @103 rd=%0h", o_data.rd);

    // lbu same
    set_item(4'd3, 5'd0, 32'h0, 1, 0, 0, MEM_BYTE, 0, 32'h103, 5'd8);
    tick();
    i_bus_ready = 1'b1;
    tick();
    i_bus_ready = 1'b0;
    exp_data = '{tag: 4'd3, inst_rd: 5'd8, rd: 32'h0000_0080};
    chk("lbu_data", o_data, exp_data);
    $display("lbu @103 rd=%0h", o_data.rd);

    // sh 0xBEEF @0x102 read-modify-write over 0x11223344
    set_item(4'd4, 5'd0, 32'h0000_BEEF, 0, 1, 0, MEM_HALF, 0, 32'h102, 5'd9);
    tick();
    chk("sh_rd_request", o_bus_request, 1);
    chk("sh_rd_rw", o_bus_rw, 0);
    chk("sh_rd_address", o_bus_address, 32'h100);
    chk("sh_busy1", o_busy, 1);
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'h1122_3344;
    tick();
    i_bus_ready = 1'b0;
    // later input changes must not disturb the latched store
    i_data.rd          = 32'hFFFF_FFFF;
    i_data.mem_address = 32'h300;
    chk("sh_gap_request", o_bus_request, 0);
    chk("sh_busy2", o_busy, 1);
    chk("sh_tag_hold", o_data.tag, 3);
    tick();
    chk("sh_wr_request", o_bus_request, 1);
    chk("sh_wr_rw", o_bus_rw, 1);
    chk("sh_wr_address", o_bus_address, 32'h100);
    chk("sh_wr_wdata", o_bus_wdata, 32'hBEEF_3344);
    chk("sh_busy3", o_busy, 1);
    tick();
    chk("sh_wr_wdata_stable", o_bus_wdata, 32'hBEEF_3344);
    i_bus_ready = 1'b1;
    tick();
    i_bus_ready = 1'b0;
    chk("sh_done_tag", o_data.tag, 4);
    chk("sh_done_inst_rd", o_data.inst_rd, 0);
    chk("sh_done_request", o_bus_request, 0);
    $display("sh @102 wrote=%0h", o_bus_wdata);

    // sw 0xDEADBEEF @0x200, ready after 5 cycles
    set_item(4'd5, 5'd0, 32'hDEAD_BEEF, 0, 1, 0, MEM_WORD, 0, 32'h200, 5'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("sw_request", o_bus_request, 1);
      chk("sw_rw", o_bus_rw, 1);
      chk("sw_address", o_bus_address, 32'h200);
      chk("sw_wdata", o_bus_wdata, 32'hDEAD_BEEF);
      chk("sw_tag_wait", o_data.tag, 4);
      tick();
    end
    i_bus_ready = 1'b1;
    tick();
    i_bus_ready = 1'b0;
    chk("sw_tag", o_data.tag, 5);
    chk("sw_request_drop", o_bus_request, 0);
    $display("sw @200 tag=%0d", o_data.tag);

    // lw misaligned @0x201
    set_item(4'd6, 5'd0, 32'h0, 1, 0, 0, MEM_WORD, 0, 32'h201, 5'd4);
    #1;
    chk("lw_mis_busy", o_busy, 1);
    tick();
    chk("lw_mis_fault", o_fault, 1);
    chk("lw_mis_request", o_bus_request, 0);
    chk("lw_mis_tag", o_data.tag, 6);
    chk("lw_mis_busy_after", o_busy, 0);
    $display("lw @201 fault=%0d", o_fault);

    // flush held until ready
    set_item(4'd7, 5'd0, 32'h0, 0, 0, 1, MEM_WORD, 0, 32'h0, 5'd0);
    tick();
    chk("flush_set", o_bus_flush, 1);
    chk("flush_request", o_bus_request, 0);
    tick();
    tick();
    chk("flush_held", o_bus_flush, 1);
    chk("flush_tag_wait", o_data.tag, 6);
    i_bus_ready = 1'b1;
    tick();
    i_bus_ready = 1'b0;
    chk("flush_drop", o_bus_flush, 0);
    chk("flush_tag", o_data.tag, 7);
    chk("fault_sticky", o_fault, 1);
    $display("flush tag=%0d", o_data.tag);

    // stray ready while idle
    i_bus_ready = 1'b1;
    tick();
    i_bus_ready = 1'b0;
    chk("stray_request", o_bus_request, 0);
    chk("stray_tag", o_data.tag, 7);
    $display("stray ready ignored tag=%0d", o_data.tag);

    // sb 0xAA @0x101, reset while in RMW_WRITE
    set_item(4'd8, 5'd0, 32'h0000_00AA, 0, 1, 0, MEM_BYTE, 0, 32'h101, 5'd0);
    tick();
    i_bus_ready = 1'b1;
    i_bus_rdata = 32'h0;
    tick();
    i_bus_ready = 1'b0;
    tick();
    chk("sb_wr_request", o_bus_request, 1);
    chk("sb_wr_wdata", o_bus_wdata, 32'h0000_AA00);
    i_reset = 1'b1;
    set_item(4'd9, 5'd3, 32'h55, 0, 0, 0, MEM_WORD, 0, 32'h0, 5'd0);
    #1;
    chk("rst_request", o_bus_request, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_fault", o_fault, 0);
    tick();
    i_reset = 1'b0;
    tick();
    exp_data = '{tag: 4'd9, inst_rd: 5'd3, rd: 32'h55};
    chk("post_rst_data", o_data, exp_data);
    chk("post_rst_request", o_bus_request, 0);
    $display("reset in RMW_WRITE, next tag=%0d", o_data.tag);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
